// File: rtl/alu.sv
// Registered ALU for the CPU datapath: one op per clock, result plus five status flags.
// The result reaches the shared bus only while assert_bus is high.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lhs_in,
  input  logic [WIDTH-1:0] rhs_in,
  input  logic [3:0]       operation,
  input  logic             assert_bus,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_en,
  output logic             flag_zero,
  output logic             flag_acarry,
  output logic             flag_lcarry,
  output logic             flag_sign,
  output logic             flag_overflow
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SHL  = 4'h1;
  localparam logic [3:0] OP_SHR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ADDC = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;
  localparam logic [3:0] OP_DEC  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_SUBB = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_AND  = 4'hA;
  localparam logic [3:0] OP_OR   = 4'hB;
  localparam logic [3:0] OP_NOT  = 4'hC;
  localparam logic [3:0] OP_ROL  = 4'hD;
  localparam logic [3:0] OP_ROR  = 4'hE;
  localparam logic [3:0] OP_CMP  = 4'hF;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] result_q, result_d, calc;
  logic             zero_q, zero_d;
  logic             acarry_q, acarry_d;
  logic             lcarry_q, lcarry_d;
  logic             sign_q, sign_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH:0]   lhs_ext, rhs_ext, cin_ext, one_ext, ext;

  assign lhs_ext = {1'b0, lhs_in};
  assign rhs_ext = {1'b0, rhs_in};
  assign cin_ext = {{WIDTH{1'b0}}, acarry_q};
  assign one_ext = {{WIDTH{1'b0}}, 1'b1};

  // Arithmetic runs one bit wide so the carry/borrow falls out of bit WIDTH.
  always_comb begin
    result_d   = result_q;
    zero_d     = zero_q;
    acarry_d   = acarry_q;
    lcarry_d   = lcarry_q;
    sign_d     = sign_q;
    overflow_d = overflow_q;
    calc       = '0;
    ext        = '0;
    case (operation)
      OP_SHL: begin
        calc = {lhs_in[MSB-1:0], 1'b0};
        lcarry_d = lhs_in[MSB];
        overflow_d = 1'b0;
      end
      OP_SHR: begin
        calc = {1'b0, lhs_in[MSB:1]};
        lcarry_d = lhs_in[0];
        overflow_d = 1'b0;
      end
      OP_ADD, OP_ADDC: begin
        ext = lhs_ext + rhs_ext + ((operation == OP_ADDC) ? cin_ext : '0);
        calc = ext[WIDTH-1:0];
        acarry_d = ext[WIDTH];
        overflow_d = (lhs_in[MSB] == rhs_in[MSB]) && (calc[MSB] != lhs_in[MSB]);
      end
      OP_INC: begin
        ext = lhs_ext + one_ext;
        calc = ext[WIDTH-1:0];
        acarry_d = ext[WIDTH];
        overflow_d = !lhs_in[MSB] && calc[MSB];
      end
      OP_DEC: begin
        ext = lhs_ext - one_ext;
        calc = ext[WIDTH-1:0];
        acarry_d = ext[WIDTH];
        overflow_d = lhs_in[MSB] && !calc[MSB];
      end
      OP_SUB, OP_SUBB, OP_CMP: begin
        ext = lhs_ext - rhs_ext - ((operation == OP_SUBB) ? cin_ext : '0);
        calc = ext[WIDTH-1:0];
        acarry_d = ext[WIDTH];
        overflow_d = (lhs_in[MSB] != rhs_in[MSB]) && (calc[MSB] != lhs_in[MSB]);
      end
      OP_XOR: begin
        calc = lhs_in ^ rhs_in;
        overflow_d = 1'b0;
      end
      OP_AND: begin
        calc = lhs_in & rhs_in;
        overflow_d = 1'b0;
      end
      OP_OR: begin
        calc = lhs_in | rhs_in;
        overflow_d = 1'b0;
      end
      OP_NOT: begin
        calc = ~lhs_in;
        overflow_d = 1'b0;
      end
      OP_ROL: begin
        calc = {lhs_in[MSB-1:0], lcarry_q};
        lcarry_d = lhs_in[MSB];
        overflow_d = 1'b0;
      end
      OP_ROR: begin
        calc = {lcarry_q, lhs_in[MSB:1]};
        lcarry_d = lhs_in[0];
        overflow_d = 1'b0;
      end
      default: begin
      end
    endcase
    // CMP updates zero/sign from its difference but leaves the result register alone.
    if (operation != OP_NOP) begin
      zero_d = (calc == '0);
      sign_d = calc[MSB];
      if (operation != OP_CMP) begin
        result_d = calc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      acarry_q   <= 1'b0;
      lcarry_q   <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      acarry_q   <= acarry_d;
      lcarry_q   <= lcarry_d;
      sign_q     <= sign_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus_out       = assert_bus ? result_q : '0;
  assign bus_en        = assert_bus;
  assign flag_zero     = zero_q;
  assign flag_acarry   = acarry_q;
  assign flag_lcarry   = lcarry_q;
  assign flag_sign     = sign_q;
  assign flag_overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed scenarios with hand-derived results, then a
// randomized run against an integer-arithmetic reference model, all through a scoreboard queue.
module tb_alu;

  logic       clk;
  logic       reset;
  logic [7:0] lhs_in, rhs_in;
  logic [3:0] operation;
  logic       assert_bus;
  logic [7:0] bus_out;
  logic       bus_en;
  logic       flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Packed observation: {bus_out, bus_en, zero, acarry, lcarry, sign, overflow}
  logic [13:0] exp_q[$];
  logic [13:0] obs, expv;

  logic [7:0] m_r;
  logic       m_z, m_c, m_l, m_s, m_o;

  alu #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .lhs_in(lhs_in),
    .rhs_in(rhs_in),
    .operation(operation),
    .assert_bus(assert_bus),
    .bus_out(bus_out),
    .bus_en(bus_en),
    .flag_zero(flag_zero),
    .flag_acarry(flag_acarry),
    .flag_lcarry(flag_lcarry),
    .flag_sign(flag_sign),
    .flag_overflow(flag_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] observe();
    return {bus_out, bus_en, flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ab);
    @(negedge clk);
    operation  = op;
    lhs_in     = a;
    rhs_in     = b;
    assert_bus = ab;
    @(posedge clk);
    #1;
    operation = 4'h0;
  endtask

  // Reference model written with plain integer arithmetic on the pre-edge flag state.
  task automatic model_step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai, bi, ci, s, sa, sb, ss;
    logic [7:0] r;
    logic arith;
    ai = a; bi = b; ci = m_c;
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    r = m_r; arith = 1'b0; s = 0; ss = 0;
    case (op)
      4'h1: begin r = 8'((ai * 2) % 256); m_l = (ai >= 128); m_o = 1'b0; end
      4'h2: begin r = 8'(ai / 2); m_l = (ai % 2 == 1); m_o = 1'b0; end
      4'h3: begin s = ai + bi; ss = sa + sb; arith = 1'b1; end
      4'h4: begin s = ai + bi + ci; ss = sa + sb + ci; arith = 1'b1; end
      4'h5: begin s = ai + 1; ss = sa + 1; arith = 1'b1; end
      4'h6: begin s = ai - 1; ss = sa - 1; arith = 1'b1; end
      4'h7, 4'hF: begin s = ai - bi; ss = sa - sb; arith = 1'b1; end
      4'h8: begin s = ai - bi - ci; ss = sa - sb - ci; arith = 1'b1; end
      4'h9: begin r = a ^ b; m_o = 1'b0; end
      4'hA: begin r = a & b; m_o = 1'b0; end
      4'hB: begin r = a | b; m_o = 1'b0; end
      4'hC: begin r = 8'(255 - ai); m_o = 1'b0; end
      4'hD: begin r = 8'(((ai * 2) % 256) + (m_l ? 1 : 0)); m_l = (ai >= 128); m_o = 1'b0; end
      4'hE: begin r = 8'((ai / 2) + (m_l ? 128 : 0)); m_l = (ai % 2 == 1); m_o = 1'b0; end
      default: begin end
    endcase
    if (arith) begin
      r   = 8'((s + 256) % 256);
      m_c = (s > 255) || (s < 0);
      m_o = (ss > 127) || (ss < -128);
    end
    if (op != 4'h0) begin
      m_z = (r == 8'h00);
      m_s = r[7];
      if (op != 4'hF) m_r = r;
    end
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    reset = 1'b1; assert_bus = 1'b1; operation = 4'h0; lhs_in = 8'h00; rhs_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({8'h00, 1'b1, 5'b00000});
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus_on: got %h expected %h", obs, expv);
    end
    assert_bus = 1'b0;
    #1;
    exp_q.push_back({8'h00, 1'b0, 5'b00000});
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus_off: got %h expected %h", obs, expv);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_logic;
    logic [3:0]  ops[3]  = '{4'h3, 4'hA, 4'hB};
    logic [7:0]  as[3]   = '{8'd200, 8'h55, 8'h55};
    logic [7:0]  bs[3]   = '{8'd64, 8'hAA, 8'hAA};
    logic [13:0] exps[3] = '{{8'h08, 1'b1, 5'b01000},
                             {8'h00, 1'b1, 5'b11000},
                             {8'hFF, 1'b1, 5'b01010}};
    $display("[TB] test_logic");
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exps[i]);
      run_op(ops[i], as[i], bs[i], 1'b1);
      obs = observe(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL logic_step%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_carry_chain;
    logic [3:0]  ops[6]  = '{4'h3, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4};
    logic [7:0]  as[6]   = '{8'd200, 8'hFF, 8'h00, 8'h77, 8'h01, 8'h00};
    logic [7:0]  bs[6]   = '{8'd64, 8'hFF, 8'h00, 8'h33, 8'h01, 8'h00};
    logic [13:0] exps[6] = '{{8'h08, 1'b1, 5'b01000},
                             {8'h08, 1'b1, 5'b01000},
                             {8'h01, 1'b1, 5'b00000},
                             {8'h01, 1'b1, 5'b00000},
                             {8'h01, 1'b1, 5'b00000},
                             {8'h00, 1'b1, 5'b10000}};
    $display("[TB] test_carry_chain");
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      run_op(ops[i], as[i], bs[i], 1'b1);
      obs = observe(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL carry_step%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_subtract;
    $display("[TB] test_subtract");
    exp_q.push_back({8'h80, 1'b1, 5'b01011});
    run_op(4'h7, 8'h01, 8'h81, 1'b1);
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL sub_borrow_ovf: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_shifts;
    $display("[TB] test_shifts");
    exp_q.push_back({8'h02, 1'b1, 5'b01100});
    run_op(4'h1, 8'h81, 8'h00, 1'b1);
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL shl: got %h expected %h", obs, expv);
    end
    exp_q.push_back({8'h81, 1'b1, 5'b01010});
    run_op(4'hE, 8'h02, 8'h00, 1'b1);
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL ror: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_cmp_bus;
    $display("[TB] test_cmp_bus");
    exp_q.push_back({8'h08, 1'b1, 5'b00000});
    run_op(4'h3, 8'd5, 8'd3, 1'b1);
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL add_5_3: got %h expected %h", obs, expv);
    end
    exp_q.push_back({8'h08, 1'b1, 5'b10000});
    run_op(4'hF, 8'h08, 8'h08, 1'b1);
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL cmp_equal: got %h expected %h", obs, expv);
    end
    assert_bus = 1'b0;
    #1;
    exp_q.push_back({8'h00, 1'b0, 5'b10000});
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL bus_gated: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_reset_mid;
    $display("[TB] test_reset_mid");
    exp_q.push_back({8'h30, 1'b1, 5'b00000});
    run_op(4'h3, 8'h10, 8'h20, 1'b1);
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_add: got %h expected %h", obs, expv);
    end
    operation = 4'h1; lhs_in = 8'hC3;
    #1;
    reset = 1'b1;
    #1;
    exp_q.push_back({8'h00, 1'b1, 5'b00000});
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %h expected %h", obs, expv);
    end
    @(posedge clk);
    #1;
    exp_q.push_back({8'h00, 1'b1, 5'b00000});
    obs = observe(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL reset_over_edge: got %h expected %h", obs, expv);
    end
    @(negedge clk);
    reset = 1'b0;
    operation = 4'h0;
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       ab;
    $display("[TB] test_random");
    m_r = 8'h00; m_z = 1'b0; m_c = 1'b0; m_l = 1'b0; m_s = 1'b0; m_o = 1'b0;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ab = ($urandom_range(0, 3) != 0);
      model_step(op, a, b);
      exp_q.push_back({ab ? m_r : 8'h00, ab, m_z, m_c, m_l, m_s, m_o});
      run_op(op, a, b, ab);
      obs = observe(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("[TB] FAIL random%0d op=%h a=%h b=%h: got %h expected %h",
                 i, op, a, b, obs, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b1; operation = 4'h0; lhs_in = 8'h00; rhs_in = 8'h00; assert_bus = 1'b0;
    test_reset();
    test_logic();
    test_carry_chain();
    test_subtract();
    test_shifts();
    test_cmp_bus();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
